// File: rtl/led_mode_sequencer.sv
// LED pattern selector: two debounced push-buttons step the pattern index up/down,
// an optional periodic timer auto-advances it. Output index is always 0..NUM_MODES-1.
module led_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD     = 50000000,
  parameter int NUM_MODES       = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       auto_en,
  output logic [2:0] selector,
  output logic       mode_changed
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TW = $clog2(AUTO_PERIOD);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(AUTO_PERIOD - 1);
  localparam logic [2:0]    SEL_LAST = 3'(NUM_MODES - 1);

  // Index 0 carries the next button, index 1 the prev button.
  logic [1:0]         btn_raw;
  logic [1:0]         sync1_q;
  logic [1:0]         sync2_q;
  logic [1:0]         deb_q;
  logic [1:0]         deb_d;
  logic [1:0]         deb_dly_q;
  logic [1:0][DW-1:0] cnt_q;
  logic [1:0][DW-1:0] cnt_d;
  logic [1:0]         press;

  logic [TW-1:0]      tmr_q;
  logic [TW-1:0]      tmr_d;
  logic [2:0]         sel_q;
  logic [2:0]         sel_d;
  logic               chg_q;
  logic               chg_d;

  logic               next_p;
  logic               prev_p;
  logic               manual;
  logic               expire;
  logic [2:0]         sel_inc;
  logic [2:0]         sel_dec;

  assign btn_raw = {btn_prev, btn_next};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      deb_q     <= '0;
      deb_dly_q <= '0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      sel_q     <= '0;
      chg_q     <= 1'b0;
    end else begin
      sync1_q   <= btn_raw;
      sync2_q   <= sync1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      sel_q     <= sel_d;
      chg_q     <= chg_d;
    end
  end

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == DEB_LAST) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DW'(1);
      end
    end
  end

  assign press  = deb_q & ~deb_dly_q;
  assign next_p = press[0];
  assign prev_p = press[1];
  assign manual = next_p | prev_p;

  // Any accepted press, even a cancelling next+prev pair, restarts the auto period.
  assign expire = auto_en && !manual && (tmr_q == TMR_LAST);

  always_comb begin
    tmr_d = tmr_q + TW'(1);
    if (!auto_en || manual || (tmr_q == TMR_LAST)) begin
      tmr_d = '0;
    end
  end

  assign sel_inc = (sel_q == SEL_LAST) ? 3'd0 : sel_q + 3'd1;
  assign sel_dec = (sel_q == 3'd0) ? SEL_LAST : sel_q - 3'd1;

  always_comb begin
    sel_d = sel_q;
    chg_d = 1'b0;
    if (next_p && !prev_p) begin
      sel_d = sel_inc;
      chg_d = 1'b1;
    end else if (prev_p && !next_p) begin
      sel_d = sel_dec;
      chg_d = 1'b1;
    end else if (expire) begin
      sel_d = sel_inc;
      chg_d = 1'b1;
    end
  end

  assign selector     = sel_q;
  assign mode_changed = chg_q;

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Bench for led_mode_sequencer: table vectors, hand-timed corner sequences and
// randomized stimulus compared every cycle against a window-based reference model.
module tb_led_mode_sequencer;

  localparam int DEB = 4;
  localparam int AP  = 10;
  localparam int NM  = 6;

  logic       clk;
  logic       rst_n;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic [2:0] selector;
  logic       mode_changed;

  int checks   = 0;
  int failures = 0;

  led_mode_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .AUTO_PERIOD    (AP),
    .NUM_MODES      (NM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .selector    (selector),
    .mode_changed(mode_changed)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- reference model ----------------
  // Button level flips once the last DEB synchronised samples all disagree with it.
  bit m_valid = 1'b0;
  int m_sel;
  bit m_mc;
  int m_elapsed;
  bit m_deb  [2];
  bit m_debp [2];
  bit m_hist [2][3];
  bit m_win  [2][DEB];
  bit m_pulse[2];
  bit m_raw;
  bit m_diff;
  bit m_manual;
  bit m_expire;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid   = 1'b1;
      m_sel     = 0;
      m_mc      = 1'b0;
      m_elapsed = 0;
      for (int b = 0; b < 2; b++) begin
        m_deb[b]  = 1'b0;
        m_debp[b] = 1'b0;
        for (int k = 0; k < 3; k++) m_hist[b][k] = 1'b0;
        for (int k = 0; k < DEB; k++) m_win[b][k] = 1'b0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        m_pulse[b] = m_deb[b] && !m_debp[b];
        m_raw = (b == 0) ? btn_next : btn_prev;
        m_hist[b][2] = m_hist[b][1];
        m_hist[b][1] = m_hist[b][0];
        m_hist[b][0] = m_raw;
        for (int k = DEB - 1; k > 0; k--) m_win[b][k] = m_win[b][k-1];
        m_win[b][0] = m_hist[b][2];
        m_diff = 1'b1;
        for (int k = 0; k < DEB; k++) if (m_win[b][k] == m_deb[b]) m_diff = 1'b0;
        m_debp[b] = m_deb[b];
        if (m_diff) m_deb[b] = !m_deb[b];
      end
      m_manual = m_pulse[0] || m_pulse[1];
      m_expire = 1'b0;
      if (!auto_en || m_manual) begin
        m_elapsed = 0;
      end else begin
        m_elapsed++;
        if (m_elapsed == AP) begin
          m_expire  = 1'b1;
          m_elapsed = 0;
        end
      end
      m_mc = 1'b1;
      if (m_pulse[0] && !m_pulse[1])      m_sel = (m_sel + 1) % NM;
      else if (m_pulse[1] && !m_pulse[0]) m_sel = (m_sel + NM - 1) % NM;
      else if (m_expire)                  m_sel = (m_sel + 1) % NM;
      else                                m_mc  = 1'b0;
    end
  end

  // Scoreboard against the model, every cycle once reset has been seen.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_sel", int'(selector), m_sel);
      chk("model_mc", int'(mode_changed), int'(m_mc));
    end
  end

  // ---------------- table vectors ----------------
  typedef struct {
    bit nx;
    bit pv;
    int hold;
    int exp_sel;
    int exp_pulses;
  } vec_t;

  vec_t vecs[12];

  task automatic apply_vec(input vec_t v, input int idx);
    int pulses;
    pulses   = 0;
    btn_next = v.nx;
    btn_prev = v.pv;
    repeat (v.hold) begin
      @(negedge clk);
      pulses += int'(mode_changed);
    end
    btn_next = 1'b0;
    btn_prev = 1'b0;
    repeat (10) begin
      @(negedge clk);
      pulses += int'(mode_changed);
    end
    chk($sformatf("vec%0d_sel", idx), int'(selector), v.exp_sel);
    chk($sformatf("vec%0d_pulses", idx), pulses, v.exp_pulses);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    failures++;
    $display("FAIL watchdog: got timeout expected finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- main test ----------------
  initial begin
    vecs[0]  = '{1'b1, 1'b0, 3,  0, 0};
    vecs[1]  = '{1'b1, 1'b0, 20, 1, 1};
    vecs[2]  = '{1'b1, 1'b0, 8,  2, 1};
    vecs[3]  = '{1'b1, 1'b0, 8,  3, 1};
    vecs[4]  = '{1'b1, 1'b0, 8,  4, 1};
    vecs[5]  = '{1'b1, 1'b0, 8,  5, 1};
    vecs[6]  = '{1'b1, 1'b0, 8,  0, 1};
    vecs[7]  = '{1'b0, 1'b1, 8,  5, 1};
    vecs[8]  = '{1'b1, 1'b1, 8,  5, 0};
    vecs[9]  = '{1'b0, 1'b1, 8,  4, 1};
    vecs[10] = '{1'b0, 1'b1, 8,  3, 1};
    vecs[11] = '{1'b0, 1'b1, 8,  2, 1};

    rst_n    = 1'b0;
    btn_next = 1'b1;
    btn_prev = 1'b0;
    auto_en  = 1'b0;

    // Reset held with the button down, then released with it still down.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_sel", int'(selector), 0);
      chk("rst_mc", int'(mode_changed), 0);
    end
    rst_n = 1'b1;
    wait_edges(6);
    chk("rel_sel_e6", int'(selector), 0);
    wait_edges(1);
    chk("rel_sel_e7", int'(selector), 1);
    chk("rel_mc_e7", int'(mode_changed), 1);
    wait_edges(1);
    chk("rel_mc_e8", int'(mode_changed), 0);
    btn_next = 1'b0;
    wait_edges(10);
    rst_n = 1'b0;
    wait_edges(2);
    rst_n = 1'b1;
    wait_edges(2);

    for (int i = 0; i < 12; i++) apply_vec(vecs[i], i);

    // Auto advance from 2, wrap, pause and resume.
    auto_en = 1'b1;
    wait_edges(9);
    chk("auto_e9", int'(selector), 2);
    wait_edges(1);
    chk("auto_e10", int'(selector), 3);
    chk("auto_e10_mc", int'(mode_changed), 1);
    wait_edges(1);
    chk("auto_e11_mc", int'(mode_changed), 0);
    wait_edges(9);
    chk("auto_e20", int'(selector), 4);
    wait_edges(10);
    chk("auto_e30", int'(selector), 5);
    wait_edges(10);
    chk("auto_wrap", int'(selector), 0);
    wait_edges(5);
    auto_en = 1'b0;
    wait_edges(30);
    chk("auto_off_hold", int'(selector), 0);
    auto_en = 1'b1;
    wait_edges(9);
    chk("auto_resume_e9", int'(selector), 0);
    wait_edges(1);
    chk("auto_resume_e10", int'(selector), 1);

    // Prev press accepted on the same edge as auto expiry at selector 3.
    auto_en = 1'b0;
    apply_vec('{1'b1, 1'b0, 8, 2, 1}, 12);
    apply_vec('{1'b1, 1'b0, 8, 3, 1}, 13);
    auto_en = 1'b1;
    wait_edges(3);
    btn_prev = 1'b1;
    wait_edges(6);
    chk("prio_e8", int'(selector), 3);
    wait_edges(1);
    chk("prio_e9", int'(selector), 2);
    chk("prio_e9_mc", int'(mode_changed), 1);
    wait_edges(1);
    chk("prio_e10_sel", int'(selector), 2);
    chk("prio_e10_mc", int'(mode_changed), 0);
    btn_prev = 1'b0;
    wait_edges(8);
    chk("prio_e18", int'(selector), 2);
    wait_edges(1);
    chk("prio_e19", int'(selector), 3);
    chk("prio_e19_mc", int'(mode_changed), 1);

    // Reset with timer at 7 and a debounce count under way.
    wait_edges(3);
    btn_next = 1'b1;
    wait_edges(4);
    rst_n    = 1'b0;
    btn_next = 1'b0;
    wait_edges(2);
    chk("midrst_sel", int'(selector), 0);
    chk("midrst_mc", int'(mode_changed), 0);
    rst_n = 1'b1;
    wait_edges(9);
    chk("midrst_e9", int'(selector), 0);
    wait_edges(1);
    chk("midrst_e10", int'(selector), 1);

    // Randomized stimulus, checked by the model.
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 24) == 0) begin
        rst_n = 1'b0;
        wait_edges($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      btn_next = ($urandom_range(0, 2) == 0);
      btn_prev = ($urandom_range(0, 3) == 0);
      auto_en  = ($urandom_range(0, 1) == 1);
      wait_edges($urandom_range(1, 14));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_mode_sequencer.md
Name: led_mode_sequencer

Overview:
- Generates the 3-bit LED pattern selector that drives the downstream 6-way LED output multiplexer.
- Selection changes in two ways:
  - Manual: two raw push-buttons (next/prev), each synchronised, debounced and rising-edge detected.
  - Automatic: a periodic advance timer, enabled by a mode switch.
- Outputs a registered selector that is always in the range 0..5, plus a one-cycle change strobe.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive stable cycles required to accept a button level change. Minimum 1.
- AUTO_PERIOD, 50000000: cycles between automatic advances. Minimum 2.
- NUM_MODES, 6: number of valid selector values, 0..NUM_MODES-1. Maximum 8.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- btn_next  input  1  raw asynchronous button, active-high; advances selector.
- btn_prev  input  1  raw asynchronous button, active-high; steps selector back.
- auto_en  input  1  level; 1 enables timed auto-advance. Treated as synchronous.
- selector  output  3  current pattern index, registered, 0..NUM_MODES-1.
- mode_changed  output  1  registered one-cycle pulse, high in the first cycle a new selector value is visible.

Behaviour:
- Reset: clk and rst_n only; the reset is synchronous and active-low. While rst_n is sampled low:
  - selector=0, mode_changed=0.
  - Synchroniser flops, debounced states, debounce counters and auto timer all go to 0.
  - Reset mid-debounce or mid-period discards all progress.
- Synchroniser: each button passes through 2 flops (sync1, sync2) before any other use.
- Debounce, per button, on the stable register `deb` and counter `cnt`:
  - If sync2 == deb: cnt=0.
  - Else, if cnt == DEBOUNCE_CYCLES-1: deb toggles and cnt=0.
  - Otherwise cnt increments.
  - A glitch shorter than DEBOUNCE_CYCLES sampled cycles never changes deb.
- Edge detect: press pulse = deb & ~deb_d, where deb_d is deb delayed one cycle. Release generates nothing.
- Manual latency: btn_next goes high before edge 1 and stays high. Then deb rises at edge 2+DEBOUNCE_CYCLES, and selector and mode_changed update at edge 3+DEBOUNCE_CYCLES.
- Selector update priority, evaluated each cycle:
  - next pulse and prev pulse both high: no change, mode_changed=0.
  - next pulse only: selector+1; NUM_MODES-1 wraps to 0.
  - prev pulse only: selector-1; 0 wraps to NUM_MODES-1.
  - otherwise, auto timer expiry: selector+1 with the same wrap.
  - Manual pulses always win over an auto expiry in the same cycle.
- mode_changed: 1 for exactly one cycle with each selector update, else 0. It is never asserted when the value does not change.
- Auto timer, `tmr`, counting 0..AUTO_PERIOD-1:
  - auto_en=0: tmr held at 0, no auto advance.
  - auto_en=1: tmr increments each cycle. Expiry is when tmr == AUTO_PERIOD-1; on expiry tmr returns to 0.
  - Any accepted manual press (including a simultaneous next+prev) clears tmr to 0, restarting the full period.
  - The first auto advance after auto_en rises occurs AUTO_PERIOD cycles later.
- Arithmetic: wrap uses explicit compare, not modulo 8. selector can never hold a value >= NUM_MODES.
- Timer and debounce counter widths come from $clog2 of their respective parameter.
- Holding a button down produces exactly one press; there is no auto-repeat.

Test Plan:
- All tests use DEBOUNCE_CYCLES=4, AUTO_PERIOD=10, NUM_MODES=6.
- Reset: hold rst_n=0 for 3 cycles with btn_next=1 -> selector=0, mode_changed=0 throughout. Release rst_n with btn_next still high -> selector becomes 1 at edge 7 after release, mode_changed high for 1 cycle.
- Debounce: pulse btn_next high for 3 cycles, then low -> selector unchanged, mode_changed never asserted. Hold btn_next high for 20 cycles -> exactly one increment, at edge 7.
- Wrap: 6 clean btn_next presses from 0 -> sequence 1,2,3,4,5,0. One btn_prev press from 0 -> 5. Press both buttons together -> selector unchanged, mode_changed=0.
- Auto: auto_en=1 from selector=2 -> selector 3 after 10 cycles, 4 after 20, and so on, wrapping 5->0. Drop auto_en mid-period -> no further change. Raise it again -> next advance exactly 10 cycles later.
- Priority/restart: time a btn_prev press to be accepted in the same cycle as auto expiry at selector=3 -> selector=2, single mode_changed pulse. Next auto advance follows 10 cycles after that.
- Reset mid-operation: assert rst_n=0 while tmr=7 and a debounce count is in progress -> selector=0, with no late advance after release.
